// File: rtl/capture_readout_if.sv
// Output stream bundle of the capture readout: one sample per valid/ready
// handshake, with m_last flagging the final sample of a stream.
interface capture_readout_if #(
  parameter int DATA_W = 8
) ();
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/capture_readout.sv
// Reader side of the sample capture buffer. After a capture stops, it walks
// the circular sample RAM from (stop_ptr - len) and streams the last len
// samples oldest first. A 2-entry FIFO absorbs the 1-cycle RAM read latency.
module capture_readout #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int CNT_BITS = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [ADDR_W-1:0]   stop_ptr_i,
  input  logic [CNT_BITS-1:0] read_len_i,
  output logic                mem_rd_en_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  capture_readout_if.master   m_if,
  output logic                busy_o,
  output logic                done_o
);

  // One extra bit so a full-depth request (2^ADDR_W) is representable.
  localparam int LEN_W = CNT_BITS + 1;
  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1) << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  issue_cnt_q;
  logic [LEN_W-1:0]  out_cnt_q;
  logic              inflight_q;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;

  logic [LEN_W-1:0]  len_ext;
  logic [LEN_W-1:0]  eff_len;
  logic [ADDR_W-1:0] start_addr;
  logic [2:0]        level;
  logic              pop;
  logic              push;
  logic              issue;

  assign m_if.m_valid = (occ_q != 2'd0);
  assign m_if.m_data  = head_q;
  assign m_if.m_last  = (occ_q != 2'd0) && (out_cnt_q == LEN_W'(1));
  assign mem_rd_en_o  = issue;
  assign mem_addr_o   = addr_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);

  // Request clamping, issue throttle and 2-entry FIFO next state.
  always_comb begin
    len_ext    = LEN_W'(read_len_i);
    eff_len    = (len_ext > DEPTH) ? DEPTH : len_ext;
    start_addr = stop_ptr_i - eff_len[ADDR_W-1:0];
    pop        = m_if.m_valid & m_if.m_ready;
    push       = inflight_q;
    // Samples held or on their way, after this cycle's pop; never exceed 2.
    level      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == S_READ) && (issue_cnt_q != '0) && (level < 3'd2);
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    case ({push, pop})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) head_d = mem_rdata_i;
        else               tail_d = mem_rdata_i;
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        head_d = tail_q;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = mem_rdata_i;
        end else begin
          head_d = tail_q;
          tail_d = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  // Readout FSM with its address/counter/FIFO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
    end else if (abort_i) begin
      // Drop everything, including a read whose data arrives next cycle.
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      inflight_q <= issue;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      if (issue) begin
        addr_q      <= addr_q + 1'b1;
        issue_cnt_q <= issue_cnt_q - 1'b1;
      end
      if (pop) out_cnt_q <= out_cnt_q - 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q      <= start_addr;
            issue_cnt_q <= eff_len;
            out_cnt_q   <= eff_len;
            state_q     <= (eff_len == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (issue && (issue_cnt_q == LEN_W'(1))) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // The final pop is the last event; done follows in the next cycle.
          if (pop && (out_cnt_q == LEN_W'(1))) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout: a RAM model, a ready generator, an expected
// address/sample scoreboard and a monitor that checks every handshake.
module tb_capture_readout;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] stop_ptr;
  logic [8:0] read_len;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;

  capture_readout_if #(.DATA_W(8)) bus ();

  capture_readout #(.DATA_W(8), .ADDR_W(8), .CNT_BITS(9)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .abort_i     (abort),
    .stop_ptr_i  (stop_ptr),
    .read_len_i  (read_len),
    .mem_rd_en_o (mem_rd_en),
    .mem_addr_o  (mem_addr),
    .mem_rdata_i (mem_rdata),
    .m_if        (bus.master),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [256];
  logic [8:0] exp_q [$];
  logic [7:0] addr_q [$];
  int         vec_cnt = 0;
  int         err_cnt = 0;
  int         hs_cnt = 0;
  int         done_cnt = 0;
  int         rmode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      err_cnt++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Sample RAM with one cycle of read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       bus.m_ready = 1'b1;
      1:       bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b0;
    endcase
  end

  // Monitor: read addresses, samples, hold-while-stalled, fill limit, done.
  always @(negedge clk) begin : mon
    logic       p;
    logic [8:0] e;
    logic [7:0] a;
    int         outst;
    logic       stall_q;
    logic [8:0] stall_v;
    if (rst) begin
      exp_q.delete();
      addr_q.delete();
      outst   = 0;
      stall_q = 1'b0;
    end else begin
      p = bus.m_valid & bus.m_ready;
      if (stall_q)
        chk("stall_hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, stall_v});
      if (mem_rd_en) begin
        chk("no_issue_when_full", 32'((outst - int'(p)) < 2), 32'd1);
        if (addr_q.size() == 0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL rd_unexpected: mem_rd_en=1 addr=%0d, required no read", mem_addr);
        end else begin
          a = addr_q.pop_front();
          chk("rd_addr", mem_addr, a);
        end
      end
      if (p) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL sample_unexpected: data=%0h last=%0b, required no sample", bus.m_data, bus.m_last);
        end else begin
          e = exp_q.pop_front();
          chk("stream_sample", {bus.m_last, bus.m_data}, e);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_queue_empty", exp_q.size(), 0);
      end
      outst   = outst + int'(mem_rd_en) - int'(p);
      stall_q = bus.m_valid & ~bus.m_ready & ~abort;
      stall_v = {bus.m_last, bus.m_data};
      if (abort) begin
        exp_q.delete();
        addr_q.delete();
        outst   = 0;
        stall_q = 1'b0;
      end
    end
  end

  task automatic expect_stream(input logic [7:0] sp, input int len);
    int         eff;
    logic [7:0] a;
    eff = (len > 256) ? 256 : len;
    a   = sp - 8'(eff);
    for (int k = 0; k < eff; k++) begin
      addr_q.push_back(a);
      exp_q.push_back({(k == eff - 1), ram[a]});
      a = a + 8'd1;
    end
  endtask

  // Pulses start in the current cycle (T0); returns early in T1.
  task automatic do_start(input logic [7:0] sp, input logic [8:0] len);
    stop_ptr = sp;
    read_len = len;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(nm, done_cnt - d0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_rd_en"}, mem_rd_en, 0);
    chk({nm, "_addr"}, mem_addr, 0);
    chk({nm, "_valid"}, bus.m_valid, 0);
    chk({nm, "_data"}, bus.m_data, 0);
    chk({nm, "_last"}, bus.m_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int h0;
    int d0;
    int n;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i * 37 + 11);
    rst = 1'b1; start = 1'b0; abort = 1'b0; stop_ptr = '0; read_len = '0;
    rmode = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Basic read: stop_ptr=10, len 4, exact cycle timing.
    expect_stream(8'd10, 4);
    do_start(8'd10, 9'd4);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      chk($sformatf("basic_rden_T%0d", t), mem_rd_en, (t <= 4));
      if (t <= 4) chk($sformatf("basic_addr_T%0d", t), mem_addr, 6 + t - 1);
      chk($sformatf("basic_valid_T%0d", t), bus.m_valid, (t >= 3 && t <= 6));
      if (t >= 3 && t <= 6) chk($sformatf("basic_data_T%0d", t), bus.m_data, ram[8'(t + 3)]);
      chk($sformatf("basic_last_T%0d", t), bus.m_last, (t == 6));
      chk($sformatf("basic_done_T%0d", t), done, (t == 7));
      chk($sformatf("basic_busy_T%0d", t), busy, (t <= 7));
    end
    @(posedge clk); #1;

    // Address wrap: 253,254,255,0,1.
    expect_stream(8'd2, 5);
    do_start(8'd2, 9'd5);
    wait_done("wrap_done", 40);

    // Backpressure: random ready with a 10-cycle hard stall.
    rmode = 1;
    h0 = hs_cnt;
    expect_stream(8'd100, 16);
    do_start(8'd100, 9'd16);
    repeat (5) @(posedge clk);
    rmode = 2;
    repeat (10) @(posedge clk);
    rmode = 1;
    wait_done("bp_done", 300);
    chk("bp_count", hs_cnt - h0, 16);
    rmode = 0;
    repeat (2) @(posedge clk); #1;

    // Zero length: done at T1, nothing read.
    do_start(8'd9, 9'd0);
    @(negedge clk);
    chk("len0_done_T1", done, 1);
    chk("len0_valid_T1", bus.m_valid, 0);
    chk("len0_rden_T1", mem_rd_en, 0);
    chk("len0_busy_T1", busy, 1);
    @(negedge clk);
    chk("len0_done_T2", done, 0);
    chk("len0_busy_T2", busy, 0);
    @(posedge clk); #1;

    // Oversize length clamps to the full buffer starting at stop_ptr.
    h0 = hs_cnt;
    expect_stream(8'd37, 300);
    do_start(8'd37, 9'd300);
    wait_done("len300_done", 400);
    chk("len300_count", hs_cnt - h0, 256);

    // Abort after 3 handshakes, then a clean read.
    h0 = hs_cnt;
    expect_stream(8'd50, 8);
    do_start(8'd50, 9'd8);
    n = 0;
    while (hs_cnt - h0 < 3 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("abort_reached_3hs", 32'(hs_cnt - h0 >= 3), 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", bus.m_valid, 0);
    chk("abort_busy", busy, 0);
    #1;
    h0 = hs_cnt;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_more_hs", hs_cnt - h0, 0);
    chk("abort_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    expect_stream(8'd200, 6);
    do_start(8'd200, 9'd6);
    wait_done("post_abort_done", 40);

    // Asynchronous reset mid-stream, then a clean read.
    expect_stream(8'd150, 16);
    do_start(8'd150, 9'd16);
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    expect_stream(8'd20, 4);
    do_start(8'd20, 9'd4);
    wait_done("post_rst_done", 40);

    // Start while busy is ignored.
    h0 = hs_cnt;
    expect_stream(8'd120, 8);
    do_start(8'd120, 9'd8);
    repeat (2) @(posedge clk); #1;
    stop_ptr = 8'd200; read_len = 9'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start_done", 60);
    chk("busy_start_count", hs_cnt - h0, 8);

    // Start in the DONE cycle is ignored (len 2: done at T5).
    expect_stream(8'd60, 2);
    do_start(8'd60, 9'd2);
    repeat (4) @(posedge clk); #1;
    stop_ptr = 8'd90; read_len = 9'd3; start = 1'b1;
    @(negedge clk);
    chk("donecyc_done", done, 1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("donecyc_busy", busy, 0);
    @(posedge clk); #1;

    // Abort and start together: abort wins.
    stop_ptr = 8'd70; read_len = 9'd4; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("abort_start_valid", bus.m_valid, 0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
